vga_fade_core: RTL and testbench

Parametrised video-stream core for a video slot that scales each colour channel of the pixel stream by a programmable brightness level. The level ramps up or down automatically, one step every N frames, so software can fade the screen in or out without per-frame intervention. It sits in the video pipeline between two stream stages: pixel in, pixel out, zero pixel latency. Control registers are written through the standard video slot write interface.

---
 rtl/vga_fade_pkg.sv | 19 +
 rtl/vga_fade_if.sv | 10 +
 rtl/vga_fade_chan.sv | 17 +
 rtl/vga_fade_core.sv | 115 +++++++++++
 tb/tb_vga_fade_core.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fade_pkg.sv
// Shared types and constants for the brightness-fade video core.
package vga_fade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FADE_UP   = 2'd1,
    ST_FADE_DOWN = 2'd2
  } fade_state_e;

  localparam logic [1:0] ADDR_CTRL  = 2'd0;
  localparam logic [1:0] ADDR_CMD   = 2'd1;
  localparam logic [1:0] ADDR_STEP  = 2'd2;
  localparam logic [1:0] ADDR_LEVEL = 2'd3;

  localparam int CMD_FADE_IN  = 0;
  localparam int CMD_FADE_OUT = 1;
  localparam int CMD_ABORT    = 2;

endpackage

// File: rtl/vga_fade_if.sv
// Video slot register write bus.
interface vga_fade_if;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  modport master (output cs, output write, output addr, output wr_data);
  modport slave  (input cs, input write, input addr, input wr_data);
endinterface

// File: rtl/vga_fade_chan.sv
// One colour channel scaled by the brightness level: (c * level) >> LW.
module vga_fade_chan #(
  parameter int CW = 4,
  parameter int LW = 4
) (
  input  logic [CW-1:0] c,
  input  logic [LW:0]   level,
  output logic [CW-1:0] y
);

  logic [CW+LW:0] prod;

  // Full-width product so unity level (2^LW) passes the channel unchanged.
  assign prod = {{(LW+1){1'b0}}, c} * {{CW{1'b0}}, level};
  assign y    = prod[LW +: CW];

endmodule

// File: rtl/vga_fade_core.sv
// Brightness fade core: register decode, fade FSM, frame counter and
// zero-latency per-channel scaling of the pixel stream.
module vga_fade_core
  import vga_fade_pkg::*;
#(
  parameter int CW  = 4,
  parameter int LW  = 4,
  parameter int FCW = 16
) (
  input  logic            clk,
  input  logic            reset,
  vga_fade_if.slave       bus,
  input  logic            frame_start,
  input  logic [3*CW-1:0] si_rgb,
  output logic [3*CW-1:0] so_rgb,
  output logic            fade_busy
);

  localparam logic [1:0]     IDLE      = ST_IDLE;
  localparam logic [1:0]     FADE_UP   = ST_FADE_UP;
  localparam logic [1:0]     FADE_DOWN = ST_FADE_DOWN;
  localparam logic [LW:0]    LVL_MAX   = {1'b1, {LW{1'b0}}};
  localparam logic [LW:0]    LVL_ONE   = {{LW{1'b0}}, 1'b1};
  localparam logic [LW:0]    LVL_ZERO  = '0;
  localparam logic [FCW-1:0] CNT_ONE   = {{(FCW-1){1'b0}}, 1'b1};

  logic [1:0]     state;
  logic [LW:0]    level;
  logic [FCW-1:0] step_reg;
  logic [FCW-1:0] frame_cnt;
  logic           bypass;

  logic           wr_en;
  logic [1:0]     sel;
  logic           cmd_wr;
  logic           do_abort;
  logic           do_out;
  logic           do_in;
  logic [FCW-1:0] step_eff;
  logic           step_hit;
  logic [LW:0]    level_in;
  logic [LW:0]    level_sat;
  logic [3*CW-1:0] scaled;
  logic           unused_bits;

  assign wr_en    = bus.cs & bus.write;
  assign sel      = bus.addr[1:0];
  assign cmd_wr   = wr_en && (sel == ADDR_CMD);
  assign do_abort = cmd_wr && bus.wr_data[CMD_ABORT];
  assign do_out   = cmd_wr && bus.wr_data[CMD_FADE_OUT] && !do_abort;
  assign do_in    = cmd_wr && bus.wr_data[CMD_FADE_IN] && !do_abort && !bus.wr_data[CMD_FADE_OUT];

  // A STEP of 0 behaves as 1; >= compare lets a shrunk STEP fire on the next frame.
  assign step_eff  = (step_reg == '0) ? CNT_ONE : step_reg;
  assign step_hit  = frame_cnt >= (step_eff - CNT_ONE);
  assign level_in  = bus.wr_data[LW:0];
  assign level_sat = (level_in > LVL_MAX) ? LVL_MAX : level_in;

  assign unused_bits = ^{bus.addr[13:2], bus.wr_data};

  // Register writes, command handling and frame-paced level stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      level     <= LVL_MAX;
      step_reg  <= CNT_ONE;
      frame_cnt <= '0;
      bypass    <= 1'b0;
    end else begin
      if (wr_en && sel == ADDR_CTRL) bypass <= bus.wr_data[0];
      if (wr_en && sel == ADDR_STEP) step_reg <= bus.wr_data[FCW-1:0];
      if (wr_en && sel == ADDR_LEVEL && state == IDLE) level <= level_sat;

      if (do_abort) begin
        state     <= IDLE;
        frame_cnt <= '0;
      end else if (do_out) begin
        frame_cnt <= '0;
        state     <= (level == LVL_ZERO) ? IDLE : FADE_DOWN;
      end else if (do_in) begin
        frame_cnt <= '0;
        state     <= (level == LVL_MAX) ? IDLE : FADE_UP;
      end else if (frame_start && state != IDLE) begin
        if (step_hit) begin
          frame_cnt <= '0;
          if (state == FADE_UP) begin
            level <= level + LVL_ONE;
            if (level == LVL_MAX - LVL_ONE) state <= IDLE;
          end else begin
            level <= level - LVL_ONE;
            if (level == LVL_ONE) state <= IDLE;
          end
        end else begin
          frame_cnt <= frame_cnt + CNT_ONE;
        end
      end
    end
  end

  assign fade_busy = (state != IDLE);

  for (genvar i = 0; i < 3; i++) begin : g_chan
    vga_fade_chan #(.CW(CW), .LW(LW)) u_chan (
      .c     (si_rgb[i*CW +: CW]),
      .level (level),
      .y     (scaled[i*CW +: CW])
    );
  end

  // Bypass selects the raw stream; level and FSM keep running underneath.
  always_comb begin
    so_rgb = bypass ? si_rgb : scaled;
  end

endmodule

// File: tb/tb_vga_fade_core.sv
// Directed plus randomized bench for vga_fade_core with a frame-level model.
module tb_vga_fade_core;
  import vga_fade_pkg::*;

  localparam int CW   = 4;
  localparam int LW   = 4;
  localparam int FCW  = 16;
  localparam int MAXL = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [11:0] si_rgb;
  logic [11:0] so_rgb;
  logic        fade_busy;

  vga_fade_if bus ();

  vga_fade_core #(.CW(CW), .LW(LW), .FCW(FCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .frame_start (frame_start),
    .si_rgb      (si_rgb),
    .so_rgb      (so_rgb),
    .fade_busy   (fade_busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: level, fade direction (+1/-1/0), frames since last step, STEP, bypass.
  int m_lvl, m_dir, m_cnt, m_step;
  bit m_byp;

  function automatic logic [11:0] ref_pix(input logic [11:0] p);
    logic [11:0] r;
    if (m_byp) return p;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = int'(p[k*4 +: 4]);
      r[k*4 +: 4] = 4'((c * m_lvl) / MAXL);
    end
    return r;
  endfunction

  task automatic model_reset();
    m_lvl = MAXL; m_dir = 0; m_cnt = 0; m_step = 1; m_byp = 0;
  endtask

  task automatic model_cycle(input bit rst, input bit fs, input bit en,
                             input logic [1:0] a, input logic [31:0] d);
    bit idle0, cmd;
    int eff, v;
    if (rst) begin
      model_reset();
      return;
    end
    idle0 = (m_dir == 0);
    cmd   = en && (a == 2'd1) && (d[2:0] != 3'b000);
    if (cmd) begin
      m_cnt = 0;
      if (d[2])      m_dir = 0;
      else if (d[1]) m_dir = (m_lvl == 0) ? 0 : -1;
      else           m_dir = (m_lvl == MAXL) ? 0 : 1;
    end else if (fs && m_dir != 0) begin
      eff = (m_step == 0) ? 1 : m_step;
      m_cnt++;
      if (m_cnt >= eff) begin
        m_cnt = 0;
        m_lvl += m_dir;
        if (m_lvl == 0 || m_lvl == MAXL) m_dir = 0;
      end
    end
    if (en) begin
      case (a)
        2'd0: m_byp = d[0];
        2'd2: m_step = int'(d[15:0]);
        2'd3: if (idle0) begin
                v = int'(d[4:0]);
                m_lvl = (v > MAXL) ? MAXL : v;
              end
        default: ;
      endcase
    end
  endtask

  task automatic chk12(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive, advance the model, then compare a fresh random pixel.
  task automatic cyc(input bit rst, input bit fs, input bit csv, input bit wr,
                     input logic [1:0] a, input logic [31:0] d);
    logic [11:0] hi;
    hi = 12'($urandom);
    reset        = rst;
    frame_start  = fs;
    bus.cs       = csv;
    bus.write    = wr;
    bus.addr     = {hi, a};
    bus.wr_data  = d;
    @(posedge clk);
    #1;
    model_cycle(rst, fs, csv && wr, a, d);
    reset       = 1'b0;
    frame_start = 1'b0;
    bus.cs      = 1'b0;
    bus.write   = 1'b0;
    si_rgb      = 12'($urandom);
    #1;
    chk12("model_pixel", so_rgb, ref_pix(si_rgb));
    chk1("model_busy", fade_busy, m_dir != 0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic frame();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  task automatic px(input string tag, input logic [11:0] in, input logic [11:0] exp);
    si_rgb = in;
    #1;
    chk12(tag, so_rgb, exp);
  endtask

  initial begin
    reset = 1'b1; frame_start = 1'b0; si_rgb = '0;
    bus.cs = 1'b0; bus.write = 1'b0; bus.addr = '0; bus.wr_data = '0;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    px("reset_pass", 12'hF84, 12'hF84);
    chk1("reset_busy", fade_busy, 1'b0);

    wr(ADDR_LEVEL, 32'd8);
    px("level8", 12'hF84, 12'h742);
    wr(ADDR_LEVEL, 32'd20);
    px("level_sat", 12'hF84, 12'hF84);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, ADDR_LEVEL, 32'd4);
    px("cs0_ignored", 12'hF84, 12'hF84);

    wr(ADDR_STEP, 32'd2);
    wr(ADDR_CMD, 32'h2);
    chk1("fade_out_busy", fade_busy, 1'b1);
    wr(ADDR_LEVEL, 32'd3);
    px("level_wr_in_fade", 12'hFFF, 12'hFFF);
    for (int i = 1; i <= 32; i++) begin
      frame();
      if (i == 1)  px("fo_p1", 12'hFFF, 12'hFFF);
      if (i == 2)  px("fo_p2", 12'hFFF, 12'hEEE);
      if (i == 31) chk1("fo_p31_busy", fade_busy, 1'b1);
      if (i == 32) begin
        px("fo_p32", 12'hFFF, 12'h000);
        chk1("fo_p32_busy", fade_busy, 1'b0);
      end
    end

    wr(ADDR_LEVEL, 32'd16);
    wr(ADDR_STEP, 32'd1);
    wr(ADDR_CMD, 32'h2);
    for (int i = 0; i < 5; i++) frame();
    px("rev_l11", 12'hFFF, 12'hAAA);
    wr(ADDR_CMD, 32'h1);
    for (int i = 0; i < 4; i++) frame();
    chk1("rev_busy", fade_busy, 1'b1);
    frame();
    px("rev_l16", 12'hFFF, 12'hFFF);
    chk1("rev_idle", fade_busy, 1'b0);

    wr(ADDR_LEVEL, 32'd3);
    wr(ADDR_STEP, 32'd2);
    wr(ADDR_CMD, 32'h2);
    frame();
    cyc(1'b0, 1'b1, 1'b1, 1'b1, ADDR_CMD, 32'h1);
    px("coinc_l3", 12'hFFF, 12'h222);
    frame();
    px("coinc_cnt0", 12'hFFF, 12'h222);
    wr(ADDR_CMD, 32'h7);
    px("abort_hold", 12'hFFF, 12'h222);
    chk1("abort_idle", fade_busy, 1'b0);
    wr(ADDR_LEVEL, 32'd9);
    px("abort_lvl9", 12'hFFF, 12'h888);

    wr(ADDR_LEVEL, 32'd6);
    wr(ADDR_STEP, 32'd1);
    wr(ADDR_CMD, 32'h1);
    frame();
    wr(ADDR_CTRL, 32'd1);
    px("bypass_on", 12'h5A3, 12'h5A3);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    px("rst_unity", 12'hF84, 12'hF84);
    chk1("rst_busy", fade_busy, 1'b0);
    wr(ADDR_LEVEL, 32'd8);
    px("rst_bypass0", 12'hF84, 12'h742);

    for (int n = 0; n < 800; n++) begin
      int op;
      logic [1:0]  a;
      logic [31:0] d;
      op = $urandom_range(0, 99);
      a  = 2'($urandom);
      case (a)
        2'd1:    d = {$urandom, 3'($urandom)} & 32'h7 | (32'($urandom) & 32'hFFF0);
        2'd2:    d = 32'($urandom_range(0, 3)) | (32'($urandom) & 32'hFFFF_0000);
        2'd3:    d = 32'($urandom_range(0, 31));
        default: d = 32'($urandom);
      endcase
      if (op < 1)       cyc(1'b1, 1'($urandom), 1'b1, 1'b1, a, d);
      else if (op < 45) frame();
      else if (op < 75) wr(a, d);
      else if (op < 85) cyc(1'b0, 1'($urandom), 1'b0, 1'b1, a, d);
      else if (op < 95) cyc(1'b0, 1'b1, 1'b1, 1'b1, a, d);
      else              cyc(1'b0, 1'b0, 1'b0, 1'b0, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
